// File: rtl/dht11_pkg.sv
`default_nettype none
// ============================================================================
// dht11_pkg : shared state/error types and frame constants for the DHT11 engine
// Rev 1.0
// ============================================================================
package dht11_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_LOW = 4'd1,
        ST_RELEASE   = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_CHECK     = 4'd7,
        ST_FAIL      = 4'd8,
        ST_DONE      = 4'd9
    } dht_state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_NORESP = 2'd1,
        ERR_BITTO  = 2'd2,
        ERR_CSUM   = 2'd3
    } dht_err_e;

    localparam int C_BYTE_HUM_INT = 0;
    localparam int C_BYTE_HUM_DEC = 1;
    localparam int C_BYTE_TMP_INT = 2;
    localparam int C_BYTE_TMP_DEC = 3;
    localparam int C_BYTE_CSUM    = 4;
    localparam int NUM_BITS       = 40;
    localparam int US_CNT_W       = 15;

    // Byte 0 is the first byte on the wire and sits in the top of the frame.
    function automatic logic [7:0] frame_byte(input logic [NUM_BITS-1:0] frame, input int idx);
        return 8'(frame >> (8 * (C_BYTE_CSUM - idx)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_us_tick.sv
`default_nettype none
// ============================================================================
// dht11_us_tick : microsecond prescaler, one-cycle tick, restartable
// Rev 1.0
// ============================================================================
module dht11_us_tick #(
    parameter int TICKS_PER_US = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int              CNT_W  = $clog2(TICKS_PER_US);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICKS_PER_US - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_restart || (cnt_q == C_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/dht11_ctrl.sv
`default_nettype none
// ============================================================================
// dht11_ctrl : DHT11 single-wire sequencer (start pulse, 40-bit read, checksum)
// Rev 1.0
// ============================================================================
module dht11_ctrl
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int START_LOW_US   = 18000,
    parameter int TIMEOUT_US     = 100,
    parameter int BIT1_THRESH_US = 50
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       start,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] tmp_int,
    output logic [7:0] tmp_dec
);

    localparam int                  TICKS_PER_US   = CLK_FREQ_HZ / 1_000_000;
    localparam logic [US_CNT_W-1:0] C_START_LAST   = US_CNT_W'(START_LOW_US - 1);
    localparam logic [US_CNT_W-1:0] C_TIMEOUT_LAST = US_CNT_W'(TIMEOUT_US - 1);
    // The fall strobe lands one cycle before the count would reach the full
    // width, so a pulse of exactly BIT1_THRESH_US reads BIT1_THRESH_US-1 here.
    localparam logic [US_CNT_W-1:0] C_BIT1_CNT     = US_CNT_W'(BIT1_THRESH_US - 1);
    localparam logic [5:0]          C_LAST_BIT     = 6'(NUM_BITS - 1);

    dht_state_e            state_q, state_d;
    dht_err_e              err_q, err_d;
    dht_err_e              fail_code_q, fail_code_d;
    logic [US_CNT_W-1:0]   us_cnt_q, us_cnt_d;
    logic [5:0]            bit_idx_q, bit_idx_d;
    logic [NUM_BITS-1:0]   shift_q, shift_d;
    logic [7:0]            hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
    logic [7:0]            tmp_int_q, tmp_int_d, tmp_dec_q, tmp_dec_d;
    logic                  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic                  dht_oe_q, dht_oe_d, busy_q, busy_d, done_q, done_d;

    logic                  w_rise, w_fall, w_tick, w_restart, w_timeout;
    logic [7:0]            w_csum;

    assign w_rise    = sync2_q & ~prev_q;
    assign w_fall    = ~sync2_q & prev_q;
    assign w_restart = (state_d != state_q);
    assign w_timeout = w_tick && (us_cnt_q >= C_TIMEOUT_LAST);
    assign w_csum    = frame_byte(shift_q, C_BYTE_HUM_INT) + frame_byte(shift_q, C_BYTE_HUM_DEC)
                     + frame_byte(shift_q, C_BYTE_TMP_INT) + frame_byte(shift_q, C_BYTE_TMP_DEC);

    dht11_us_tick #(
        .TICKS_PER_US (TICKS_PER_US)
    ) u_us_tick (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        us_cnt_d = us_cnt_q;
        if (w_restart) begin
            us_cnt_d = '0;
        end else if (w_tick && (us_cnt_q != '1)) begin
            us_cnt_d = us_cnt_q + US_CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        fail_code_d = fail_code_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hum_int_d   = hum_int_q;
        hum_dec_d   = hum_dec_q;
        tmp_int_d   = tmp_int_q;
        tmp_dec_d   = tmp_dec_q;
        sync1_d     = dht_in;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;

        // Edges are tested before timeouts so a coincident edge always wins.
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START_LOW;
                    err_d   = ERR_NONE;
                end
            end
            ST_START_LOW: begin
                if (w_tick && (us_cnt_q >= C_START_LAST)) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_fall) begin
                    state_d = ST_RESP_LOW;
                end else if (w_timeout) begin
                    state_d     = ST_FAIL;
                    fail_code_d = ERR_NORESP;
                end
            end
            ST_RESP_LOW: begin
                if (w_rise) begin
                    state_d = ST_RESP_HIGH;
                end else if (w_timeout) begin
                    state_d     = ST_FAIL;
                    fail_code_d = ERR_NORESP;
                end
            end
            ST_RESP_HIGH: begin
                if (w_fall) begin
                    state_d   = ST_BIT_LOW;
                    bit_idx_d = '0;
                end else if (w_timeout) begin
                    state_d     = ST_FAIL;
                    fail_code_d = ERR_NORESP;
                end
            end
            ST_BIT_LOW: begin
                if (w_rise) begin
                    state_d = ST_BIT_HIGH;
                end else if (w_timeout) begin
                    state_d     = ST_FAIL;
                    fail_code_d = ERR_BITTO;
                end
            end
            ST_BIT_HIGH: begin
                if (w_fall) begin
                    shift_d = {shift_q[NUM_BITS-2:0], (us_cnt_q >= C_BIT1_CNT)};
                    if (bit_idx_q == C_LAST_BIT) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d   = ST_BIT_LOW;
                        bit_idx_d = bit_idx_q + 6'd1;
                    end
                end else if (w_timeout) begin
                    state_d     = ST_FAIL;
                    fail_code_d = ERR_BITTO;
                end
            end
            ST_CHECK: begin
                state_d = ST_DONE;
                if (w_csum == frame_byte(shift_q, C_BYTE_CSUM)) begin
                    err_d     = ERR_NONE;
                    hum_int_d = frame_byte(shift_q, C_BYTE_HUM_INT);
                    hum_dec_d = frame_byte(shift_q, C_BYTE_HUM_DEC);
                    tmp_int_d = frame_byte(shift_q, C_BYTE_TMP_INT);
                    tmp_dec_d = frame_byte(shift_q, C_BYTE_TMP_DEC);
                end else begin
                    err_d = ERR_CSUM;
                end
            end
            ST_FAIL: begin
                state_d = ST_DONE;
                err_d   = fail_code_q;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        dht_oe_d = (state_d == ST_START_LOW);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            err_q       <= ERR_NONE;
            fail_code_q <= ERR_NONE;
            us_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hum_int_q   <= '0;
            hum_dec_q   <= '0;
            tmp_int_q   <= '0;
            tmp_dec_q   <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            dht_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            fail_code_q <= fail_code_d;
            us_cnt_q    <= us_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hum_int_q   <= hum_int_d;
            hum_dec_q   <= hum_dec_d;
            tmp_int_q   <= tmp_int_d;
            tmp_dec_q   <= tmp_dec_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            dht_oe_q    <= dht_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dht_oe  = dht_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign hum_int = hum_int_q;
    assign hum_dec = hum_dec_q;
    assign tmp_int = tmp_int_q;
    assign tmp_dec = tmp_dec_q;

endmodule
`default_nettype wire

// File: tb/tb_dht11_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dht11_ctrl : directed bench for dht11_ctrl with a behavioural DHT11 sensor
// Rev 1.0
// ============================================================================
module tb_dht11_ctrl;

    logic       ACLK    = 1'b0;
    logic       ARESETN = 1'b1;
    logic       start   = 1'b0;
    logic       line    = 1'b1;
    logic       dht_in;
    logic       dht_oe, busy, done;
    logic [1:0] err;
    logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;

    int n_cmp    = 0;
    int n_mis    = 0;
    int done_cnt = 0;
    int hw[40];
    int k;
    int oe_cycles;
    int d0;

    // Open-drain pad: host drives low when dht_oe, otherwise sensor or pull-up.
    assign dht_in = dht_oe ? 1'b0 : line;

    dht11_ctrl #(
        .CLK_FREQ_HZ    (10_000_000),
        .START_LOW_US   (20),
        .TIMEOUT_US     (100),
        .BIT1_THRESH_US (50)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .start   (start),
        .dht_in  (dht_in),
        .dht_oe  (dht_oe),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .hum_int (hum_int),
        .hum_dec (hum_dec),
        .tmp_int (tmp_int),
        .tmp_dec (tmp_dec)
    );

    always #50 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic us(input int n);
        repeat (n * 10) @(negedge ACLK);
    endtask

    task automatic chk_data(input string tag, input logic [7:0] hi, input logic [7:0] hd,
                            input logic [7:0] ti, input logic [7:0] td);
        chk({tag, "_hum_int"}, hum_int, hi);
        chk({tag, "_hum_dec"}, hum_dec, hd);
        chk({tag, "_tmp_int"}, tmp_int, ti);
        chk({tag, "_tmp_dec"}, tmp_dec, td);
    endtask

    // Issue start, then count the cycles the pad is driven low.
    task automatic run_start(input string tag, input bit hold);
        @(negedge ACLK);
        start = 1'b1;
        @(negedge ACLK);
        if (!hold) start = 1'b0;
        chk({tag, "_busy_hi"}, busy, 1);
        chk({tag, "_oe_hi"}, dht_oe, 1);
        chk({tag, "_err_clr"}, err, 0);
        oe_cycles = 1;
        while (dht_oe === 1'b1 && oe_cycles < 1000) begin
            @(negedge ACLK);
            if (dht_oe === 1'b1) oe_cycles++;
        end
        chk({tag, "_oe_len"}, oe_cycles, 200);
    endtask

    task automatic prep(input logic [39:0] f);
        for (int i = 0; i < 40; i++) hw[i] = f[39 - i] ? 60 : 20;
    endtask

    // Sensor response plus nbits data bits; leaves the line low afterwards.
    task automatic respond(input int nbits);
        us(20);
        line = 1'b0; us(80);
        line = 1'b1; us(80);
        for (int i = 0; i < nbits; i++) begin
            line = 1'b0; us(5);
            line = 1'b1; us(hw[i]);
        end
        line = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        k = 0;
        while (done !== 1'b1 && k < maxc) begin
            @(negedge ACLK);
            k++;
        end
        chk({tag, "_done_seen"}, done, 1);
    endtask

    initial begin
        #10 ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_oe", dht_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk_data("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        ARESETN = 1'b1;
        repeat (5) @(negedge ACLK);

        // Good frame
        d0 = done_cnt;
        prep(40'h37_00_19_00_50);
        run_start("good", 1'b0);
        respond(40);
        wait_done("good", 50);
        chk("good_err", err, 0);
        chk_data("good", 8'h37, 8'h00, 8'h19, 8'h00);
        @(negedge ACLK);
        chk("good_busy_lo", busy, 0);
        line = 1'b1;
        us(10);
        chk("good_done_once", done_cnt - d0, 1);

        // Silent sensor
        run_start("silent", 1'b0);
        wait_done("silent", 1100);
        chk("silent_latency", (k >= 1000 && k <= 1003), 1);
        chk("silent_err", err, 1);
        chk_data("silent", 8'h37, 8'h00, 8'h19, 8'h00);
        @(negedge ACLK);
        chk("silent_busy_lo", busy, 0);

        // Bit-width boundaries: 49->0, 50->1, 27->0, 70->1 give top nibble 0101
        prep(40'h52_00_10_05_67);
        hw[0] = 49; hw[1] = 50; hw[2] = 27; hw[3] = 70;
        run_start("bnd", 1'b0);
        respond(40);
        wait_done("bnd", 50);
        chk("bnd_err", err, 0);
        chk_data("bnd", 8'h52, 8'h00, 8'h10, 8'h05);
        line = 1'b1;
        us(10);

        // Checksum error
        prep(40'h37_00_19_00_51);
        run_start("csum", 1'b0);
        respond(40);
        wait_done("csum", 50);
        chk("csum_err", err, 3);
        chk_data("csum", 8'h52, 8'h00, 8'h10, 8'h05);
        line = 1'b1;
        us(10);

        // Sensor stops after bit 12
        prep(40'h37_00_19_00_50);
        run_start("stop12", 1'b0);
        respond(12);
        wait_done("stop12", 1100);
        chk("stop12_err", err, 2);
        chk_data("stop12", 8'h52, 8'h00, 8'h10, 8'h05);
        @(negedge ACLK);
        chk("stop12_busy_lo", busy, 0);
        line = 1'b1;
        us(10);

        // start held through busy, then reset while in a bit high phase
        d0 = done_cnt;
        run_start("rst_mid", 1'b1);
        us(20);
        line = 1'b0; us(80);
        line = 1'b1; us(80);
        chk("rst_mid_busy", busy, 1);
        line = 1'b0; us(5);
        line = 1'b1; us(20);
        start = 1'b0;
        ARESETN = 1'b0;
        #1;
        chk("rst_mid_oe", dht_oe, 0);
        chk("rst_mid_busy_lo", busy, 0);
        chk("rst_mid_err", err, 0);
        chk_data("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        us(30);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        chk("rst_mid_idle_busy", busy, 0);
        chk("rst_mid_idle_oe", dht_oe, 0);
        chk("rst_mid_idle_hum", hum_int, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dht11_ctrl.md
# dht11_ctrl

Single-wire protocol sequencer for the DHT11 humidity/temperature sensor; the engine behind the myip_dht11 AXI4-Lite register slave. On a start request it drives the host start pulse, waits for the sensor response, samples 40 data bits by pulse width, verifies the checksum and publishes humidity/temperature bytes with a done pulse and error code. The AXI slave owns the registers and the tri-state pad; this block owns all protocol timing.

## Interface
- CLK_FREQ_HZ, 100_000_000: ACLK frequency; TICKS_PER_US = CLK_FREQ_HZ/1_000_000, integer, ≥2.
- START_LOW_US, 18000: host start-pulse length in µs.
- TIMEOUT_US, 100: maximum wait for any sensor edge.
- BIT1_THRESH_US, 50: high-phase length at or above which a bit reads as 1.

- ACLK  in  1  clock.
- ARESETN  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; honoured only while busy=0.
- dht_in  in  1  raw pad input, asynchronous.
- dht_oe  out  1  1 = pad driven low; 0 = released (pull-up).
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of every transaction, pass or fail.
- err  out  2  0 ok, 1 no response, 2 bit timeout, 3 checksum; held until next start.
- hum_int, hum_dec, tmp_int, tmp_dec  out  8 each  last checksum-valid reading.

## Operation
- dht_in passes a 2-flop synchronizer, then a 1-flop edge detector (rise/fall strobes).
- µs tick: prescaler pulses once per TICKS_PER_US cycles; restarted on every state entry, so the µs counter (15 bits) starts at 0 per state.
- FSM states and transitions:
  - IDLE: dht_oe=0, busy=0. start → START_LOW; err cleared.
  - START_LOW: dht_oe=1; after START_LOW_US µs → RELEASE.
  - RELEASE: dht_oe=0; fall → RESP_LOW; TIMEOUT_US elapsed → FAIL(err=1).
  - RESP_LOW: rise → RESP_HIGH; timeout → FAIL(1).
  - RESP_HIGH: fall → BIT_LOW, bit index=0; timeout → FAIL(1).
  - BIT_LOW: rise → BIT_HIGH; timeout → FAIL(2).
  - BIT_HIGH: fall → shift in (µs count ≥ BIT1_THRESH_US), MSB first; if index=39 → CHECK else index+1, BIT_LOW; timeout → FAIL(2).
  - CHECK: (b0+b1+b2+b3) mod 256 == b4 → load output regs, err=0; else err=3, outputs unchanged. → DONE.
  - FAIL: latch err → DONE.
  - DONE: done=1 one cycle → IDLE.
- Byte order: b0 hum_int, b1 hum_dec, b2 tmp_int, b3 tmp_dec, b4 checksum.
- start while busy ignored; no queueing. Inter-read spacing (≥1 s) is software's job.

## Timing
- Reset: state IDLE, dht_oe=0, busy=0, done=0, err=0, all data outputs 0x00, synchronizer flops 1 (idle-high line).
- start sampled at cycle N → dht_oe=1 and busy=1 at N+1.
- Pad-edge-to-strobe latency 3 cycles; pulse widths measured with ±1 µs resolution.
- Data regs and err update in the same cycle done rises; busy falls the cycle after done.
- Edge and timeout in same cycle: edge wins.
- ARESETN asserted mid-transaction: immediate return to reset values, pad released, no done pulse.

## Structure
- Package dht11_pkg: state enum, err code enum (ERR_NONE, ERR_NORESP, ERR_BITTO, ERR_CSUM), byte-index constants.
- Sub-module dht11_us_tick: prescaler with restart input, one-cycle tick output.
- Synchronizer, edge detect, FSM, 40-bit shift register and checksum inline in dht11_ctrl.

## Test plan
Bench uses START_LOW_US=20, CLK_FREQ_HZ=10_000_000 and a behavioural sensor model.
- Good frame 0x37,0x00,0x19,0x00,0x50 → done once, err=0, hum_int=0x37, tmp_int=0x19, dht_oe high exactly 20 µs.
- Sensor silent after start → done ~100 µs after release, err=1, data regs keep previous values.
- Sensor stops after bit 12 → err=2, busy drops, data unchanged.
- Checksum byte 0x51 on the frame above → err=3, outputs keep prior values.
- Bit-width boundaries: high 49 µs → 0, 50 µs → 1, 27 µs → 0, 70 µs → 1.
- start held during busy, then ARESETN pulse mid-BIT_HIGH → no second transaction, all outputs at reset values, dht_oe=0, no done.
